// File: rtl/dw_pixel_streamer.sv
// dw_pixel_streamer: buffered CHANNELS x FS x FS pixel frame scanner with valid/ready output
// Define DW_PIXEL_STREAMER_ABORT_EN to add an abort input that cancels a scan in progress
module dw_pixel_streamer #(
    parameter int DATA_WIDTH   = 16,
    parameter int CHANNELS     = 4,
    parameter int FEATURE_SIZE = 8,
    parameter int ADDR_W       = $clog2(CHANNELS*FEATURE_SIZE*FEATURE_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic                  ready_in,
`ifdef DW_PIXEL_STREAMER_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [7:0]            channel_out,
    output logic [7:0]            row_out,
    output logic [7:0]            col_out,
    output logic                  last_out,
    output logic                  busy,
    output logic                  done
);
    localparam int DEPTH = CHANNELS*FEATURE_SIZE*FEATURE_SIZE;
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [7:0] ch, row, col;
    logic [ADDR_W-1:0] rd_addr;
    logic at_end, col_end, row_end, fire, abort_hit;
`ifdef DW_PIXEL_STREAMER_ABORT_EN
    assign abort_hit = abort && state == STREAM;
`else
    assign abort_hit = 1'b0;
`endif
    assign col_end   = col == 8'(FEATURE_SIZE-1);
    assign row_end   = row == 8'(FEATURE_SIZE-1);
    assign at_end    = col_end && row_end && ch == 8'(CHANNELS-1);
    assign valid_out = state == STREAM;
    assign fire      = valid_out && ready_in;
    assign rd_addr   = ADDR_W'(int'(ch)*FEATURE_SIZE*FEATURE_SIZE + int'(row)*FEATURE_SIZE + int'(col));
    // Combinational read so a write landing with start is visible on the first beat
    assign data_out    = valid_out ? mem[rd_addr] : '0;
    assign channel_out = ch;
    assign row_out     = row;
    assign col_out     = col;
    assign last_out    = valid_out && at_end;
    assign busy        = state != IDLE;
    assign done        = state == DONE;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? STREAM : IDLE;
            STREAM:  state_nx = abort_hit ? IDLE : (fire && at_end) ? DONE : STREAM;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (!rst_n || abort_hit || (fire && at_end)) begin
            ch  <= 8'd0;
            row <= 8'd0;
            col <= 8'd0;
        end else if (fire) begin
            col <= col_end ? 8'd0 : col + 8'd1;
            row <= col_end ? (row_end ? 8'd0 : row + 8'd1) : row;
            ch  <= (col_end && row_end) ? ch + 8'd1 : ch;
        end
    end
    // Buffer has no reset so frame contents survive rst_n
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE && int'(wr_addr) < DEPTH) mem[wr_addr] <= wr_data;
    end
endmodule

// File: doc/dw_pixel_streamer.md
DW_PIXEL_STREAMER -- requirements
Module: dw_pixel_streamer

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_WIDTH, 16, pixel word width.
- CHANNELS, 4, channels per frame (1..255).
- FEATURE_SIZE, 8, frame height and width (2..255).
- ADDR_W, $clog2(CHANNELS*FEATURE_SIZE*FEATURE_SIZE), buffer address width.
REQ-002 Ports SHALL be, one per line:
- clk, in, 1, sole clock; all logic samples on its rising edge.
- rst_n, in, 1, synchronous active-low reset.
- wr_en, in, 1, buffer write strobe.
- wr_addr, in, ADDR_W, write address = ch*FS*FS + row*FS + col.
- wr_data, in, DATA_WIDTH, write data.
- start, in, 1, begin one frame scan.
- ready_in, in, 1, downstream can accept a beat.
- valid_out, out, 1, beat present.
- data_out, out, DATA_WIDTH, pixel value.
- channel_out, out, 8, channel tag.
- row_out, out, 8, row tag.
- col_out, out, 8, column tag.
- last_out, out, 1, final beat of the frame.
- busy, out, 1, scan in progress.
- done, out, 1, one-cycle pulse after the final beat is accepted.

Function
REQ-003 The block SHALL hold a CHANNELS*FEATURE_SIZE*FEATURE_SIZE x DATA_WIDTH register buffer.
REQ-004 When wr_en=1 in IDLE, the block SHALL write wr_data at wr_addr.
REQ-005 Writes to addresses >= depth, and any wr_en outside IDLE, SHALL be ignored.
REQ-006 The FSM SHALL have three states: IDLE, STREAM and DONE.
- IDLE->STREAM when start=1.
- STREAM->DONE when the final beat is accepted.
- DONE->IDLE unconditionally.
REQ-007 start SHALL be ignored outside IDLE.
REQ-008 If start and wr_en are both asserted in IDLE in the same cycle, the write SHALL complete and the scan SHALL see the new value.
REQ-009 The first beat's valid_out SHALL assert in the cycle after start is sampled (latency 1).
REQ-010 Scan order SHALL be channel outermost, then row, then column innermost, each counting from 0.
REQ-011 data_out SHALL equal buffer[channel_out*FS*FS + row_out*FS + col_out].
REQ-012 A beat SHALL transfer on a rising edge with valid_out=1 and ready_in=1.
REQ-013 While valid_out=1 and ready_in=0, data_out, channel_out, row_out, col_out and last_out SHALL remain stable.
REQ-014 valid_out SHALL NOT deassert in STREAM until the final beat transfers.
REQ-015 With ready_in held at 1, one beat SHALL transfer per cycle with no bubbles.
REQ-016 Counter wrap on transfer SHALL be:
- col wraps FS-1->0 and increments row.
- row wraps FS-1->0 and increments channel.
REQ-017 last_out SHALL be 1 only when channel_out=CHANNELS-1, row_out=FS-1 and col_out=FS-1.
REQ-018 busy SHALL be 1 in STREAM and DONE, and 0 in IDLE.
REQ-019 done SHALL be 1 only in DONE.
REQ-020 valid_out SHALL be 0 in IDLE and DONE.
REQ-021 Buffer contents SHALL persist across scans, so repeated starts replay the same frame.

Reset
REQ-022 When rst_n=0 at a rising edge, the block SHALL enter IDLE and clear all counters.
REQ-023 Output reset values SHALL be: valid_out, last_out, busy and done =0; data_out, channel_out, row_out and col_out =0.
REQ-024 Reset mid-scan SHALL abort the scan with no done pulse.
REQ-025 Reset SHALL NOT clear buffer contents.

Configuration
REQ-026 Macro DW_PIXEL_STREAMER_ABORT_EN SHALL control an abort feature.
- Defined: add input port abort (1 bit). abort=1 in STREAM SHALL force IDLE at the next edge, clear valid_out and counters, and produce no done pulse. abort SHALL be ignored in IDLE and DONE.
- Undefined: no abort port. A scan ends only by completion or reset.

Verification (CHANNELS=2, FEATURE_SIZE=4, buffer[i]=i+100)
REQ-027 ready_in=1, start pulse -> 32 consecutive beats with data 100..131; beat 5 is ch0,r1,c1,data 105; last_out only on ch1,r3,c3 (data 131); done pulses one cycle later.
REQ-028 ready_in toggles 1,0,0,1 repeatedly -> same 32-value sequence, with all outputs held stable while ready_in=0.
REQ-029 start asserted mid-scan, and wr_en to address 0 with data 0xBEEF mid-scan -> both ignored; the next scan still outputs 100 first.
REQ-030 rst_n=0 at beat 10 -> next cycle valid_out=0 and busy=0, no done; a new start replays from data 100.
REQ-031 With DW_PIXEL_STREAMER_ABORT_EN: abort at beat 7 -> valid_out=0 next cycle, no done; a restart begins at ch0,r0,c0.
REQ-032 Same cycle in IDLE: wr_en to address 0 with data 0x0007, plus start -> first beat data is 0x0007.
